// File: rtl/crc_engine.sv
// -----------------------------------------------------------------------------
// crc_engine
//
// Purpose
//   Bit-serial, parameterisable CRC engine. Each accepted data word is absorbed
//   BPC bits per clock over N = DATA_W/BPC SHIFT cycles. A word marked in_last
//   closes the frame: the XOR_OUT-adjusted CRC is published on crc_out with a
//   one-cycle crc_valid pulse, and the running register is preset to INIT.
//
// Parameters
//   CRC_W     CRC register width (8..32)
//   POLY      generator polynomial, implicit x^CRC_W term omitted
//   INIT      register preset at frame start
//   XOR_OUT   value XORed into the final CRC
//   DATA_W    input word width
//   BPC       bits absorbed per clock (DATA_W is a multiple of BPC)
//   LSB_FIRST 0 = data fed MSB first, 1 = data fed LSB first
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       word offered
//   in_ready   out  1       engine can accept a word (IDLE)
//   in_data    in   DATA_W  data word
//   in_sof     in   1       word is the first of a frame
//   in_last    in   1       word is the last of a frame
//   crc_out    out  CRC_W   final CRC of the last completed frame
//   crc_valid  out  1       one-cycle pulse marking a new crc_out
//   busy       out  1       high while in SHIFT
//
// Optional feature (macro CRC_CHECK_EN)
//   exp_crc    in   CRC_W   expected CRC, latched with the in_last word
//   crc_ok     out  1       registered with crc_valid: result == exp_crc
//   crc_err    out  1       one-cycle pulse with crc_valid on a mismatch
// -----------------------------------------------------------------------------
module crc_engine #(
    parameter int               CRC_W     = 8,
    parameter logic [CRC_W-1:0] POLY      = 8'h07,
    parameter logic [CRC_W-1:0] INIT      = 8'h00,
    parameter logic [CRC_W-1:0] XOR_OUT   = 8'h00,
    parameter int               DATA_W    = 8,
    parameter int               BPC       = 8,
    parameter bit               LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_last,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    output logic              busy
`ifdef CRC_CHECK_EN
    ,
    input  logic [CRC_W-1:0]  exp_crc,
    output logic              crc_ok,
    output logic              crc_err
`endif
);

    // Number of SHIFT cycles needed to absorb one word.
    localparam int N     = DATA_W / BPC;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Absorb one BPC-bit chunk into the CRC, one bit at a time, in the
    // configured bit order. The chunk is presented in its natural word order;
    // the order of bit consumption is decided here.
    function automatic logic [CRC_W-1:0] crc_absorb(
        input logic [CRC_W-1:0] crc_in,
        input logic [BPC-1:0]   chunk
    );
        logic [CRC_W-1:0] r;
        logic             b;
        logic             fb;
        r = crc_in;
        for (int i = 0; i < BPC; i++) begin
            if (LSB_FIRST) begin
                b = chunk[i];
            end else begin
                b = chunk[BPC-1-i];
            end
            fb = r[CRC_W-1] ^ b;
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
        return r;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   data_r;
    logic                last_r;
    logic [CRC_W-1:0]    crc_r;
    logic [CRC_W-1:0]    crc_out_r;
    logic                crc_valid_r;

    logic                accept_s;
    logic                done_s;
    logic [BPC-1:0]      chunk_s;
    logic [CRC_W-1:0]    crc_step_s;
    logic [CRC_W-1:0]    crc_final_s;

    assign accept_s    = in_valid && (state_r == ST_IDLE);
    assign done_s      = (state_r == ST_SHIFT) && (cnt_r == CNT_W'(1));
    assign crc_step_s  = crc_absorb(crc_r, chunk_s);
    assign crc_final_s = crc_step_s ^ XOR_OUT;

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_SHIFT);
    assign crc_out   = crc_out_r;
    assign crc_valid = crc_valid_r;

    // Select the chunk to absorb this cycle: the word is shifted so the next
    // chunk always sits at the end being consumed first.
    always_comb begin
        chunk_s = {BPC{1'b0}};
        if (LSB_FIRST) begin
            chunk_s = data_r[BPC-1:0];
        end else begin
            chunk_s = data_r[DATA_W-1 -: BPC];
        end
    end

    // Next-state logic for the IDLE/SHIFT controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: word capture, shift counter, running CRC and published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= {CNT_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            last_r      <= 1'b0;
            crc_r       <= INIT;
            crc_out_r   <= {CRC_W{1'b0}};
            crc_valid_r <= 1'b0;
        end else begin
            crc_valid_r <= 1'b0;
            if (accept_s) begin
                data_r <= in_data;
                last_r <= in_last;
                cnt_r  <= CNT_W'(N);
                // A start-of-frame discards any partial frame in progress.
                if (in_sof) begin
                    crc_r <= INIT;
                end
            end else if (state_r == ST_SHIFT) begin
                cnt_r <= cnt_r - CNT_W'(1);
                if (LSB_FIRST) begin
                    data_r <= data_r >> BPC;
                end else begin
                    data_r <= data_r << BPC;
                end
                if (done_s && last_r) begin
                    // Frame closes: publish and preset for the next frame.
                    crc_out_r   <= crc_final_s;
                    crc_valid_r <= 1'b1;
                    crc_r       <= INIT;
                end else begin
                    crc_r <= crc_step_s;
                end
            end
        end
    end

`ifdef CRC_CHECK_EN
    logic [CRC_W-1:0] exp_r;
    logic             crc_ok_r;
    logic             crc_err_r;
    logic             match_s;

    assign match_s = (crc_final_s == exp_r);
    assign crc_ok  = crc_ok_r;
    assign crc_err = crc_err_r;

    // Expected-CRC capture and result comparison, aligned with crc_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_r     <= {CRC_W{1'b0}};
            crc_ok_r  <= 1'b0;
            crc_err_r <= 1'b0;
        end else begin
            crc_err_r <= 1'b0;
            if (accept_s && in_last) begin
                exp_r <= exp_crc;
            end
            if (done_s && last_r) begin
                crc_ok_r  <= match_s;
                crc_err_r <= !match_s;
            end
        end
    end
`endif

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 SHALL: CRC_W, default 8, CRC register width (8..32).
REQ-002 SHALL: POLY, default 8'h07, generator polynomial, implicit x^CRC_W term omitted.
REQ-003 SHALL: INIT, default 0, register preset at frame start.
REQ-004 SHALL: XOR_OUT, default 0, value XORed into the final CRC.
REQ-005 SHALL: DATA_W, default 8, input word width.
REQ-006 SHALL: BPC, default 8, bits absorbed per clock; DATA_W is a multiple of BPC.
REQ-007 SHALL: LSB_FIRST, default 0; 0 = feed data MSB first, 1 = feed data LSB first.
REQ-008 SHALL: clk  in  1  rising-edge clock.
REQ-009 SHALL: rst  in  1  reset; synchronous and active-high.
REQ-010 SHALL: in_valid  in  1  word offered.
REQ-011 SHALL: in_ready  out  1  engine can accept a word.
REQ-012 SHALL: in_data  in  DATA_W  data word.
REQ-013 SHALL: in_sof  in  1  word is the first of a frame.
REQ-014 SHALL: in_last  in  1  word is the last of a frame.
REQ-015 SHALL: crc_out  out  CRC_W  final CRC of the last completed frame.
REQ-016 SHALL: crc_valid  out  1  one-cycle pulse marking a new crc_out.
REQ-017 SHALL: busy  out  1  high while in SHIFT.

Function
REQ-018 SHALL: use a two-state FSM, IDLE and SHIFT; in_ready = (state == IDLE).
REQ-019 SHALL: define accept as in_valid && in_ready at a rising edge.
- On accept: latch in_data and in_last.
- Load shift count N = DATA_W/BPC.
- Go to SHIFT.
- If in_sof, preset the CRC register to INIT before any shifting.
REQ-020 SHALL: absorb BPC bits per SHIFT cycle, in the order set by LSB_FIRST, one bit at a time as follows.
- fb = crc[CRC_W-1] ^ bit.
- crc = (crc << 1) ^ (fb ? POLY : 0).
REQ-021 SHALL: at the edge completing the Nth SHIFT cycle, return to IDLE.
- If the latched last = 1: crc_out <= crc ^ XOR_OUT, crc_valid <= 1 for exactly one cycle, and the CRC register is preset to INIT.
- If the latched last = 0: crc_out is unchanged and the CRC register keeps its running value.
REQ-022 SHALL: deliver the result N clocks after the accept edge; the sustained rate is one word per N+1 clocks.
REQ-023 SHALL: ignore in_valid while in SHIFT; the source holds its word until accepted.
REQ-024 SHALL: treat in_sof and in_last both set on one word as a complete single-word frame.
REQ-025 SHALL: on in_sof arriving mid-frame, discard the partial frame, restart from INIT, and emit no crc_valid for the discarded frame.
REQ-026 SHALL: continue from the running register for a word without in_sof after a completed frame, which starts from INIT because of the preset in REQ-021.
REQ-027 SHALL: hold crc_out stable between crc_valid pulses.

Reset
REQ-028 SHALL: while rst is high at a clock edge, enter IDLE with CRC register = INIT, crc_out = 0, crc_valid = 0, busy = 0, shift count = 0; in_ready is high in the cycle after rst deasserts.
REQ-029 SHALL: on rst during SHIFT, abandon the frame with no crc_valid.

Configuration
REQ-030 SHALL: define macro CRC_CHECK_EN to add port exp_crc (in, CRC_W) and ports crc_ok and crc_err (out, 1 each).
- exp_crc is latched on accept of the in_last word.
- crc_ok is registered with crc_valid and equals (crc ^ XOR_OUT) == exp_crc.
- crc_err is a one-cycle pulse, coincident with crc_valid, when there is a mismatch.
- crc_ok holds until the next crc_valid.
- crc_ok and crc_err reset to 0.
REQ-031 SHALL: without CRC_CHECK_EN, omit these ports and all comparison logic; all other behaviour is identical.

Verification
REQ-032 SHALL: defaults, single frame "123456789" (0x31..0x39, sof on first, last on ninth) -> crc_out = 0xF4, one crc_valid pulse.
REQ-033 SHALL: defaults with BPC=1 -> same 0xF4; crc_valid exactly 8 clocks after the last accept; in_ready low for those 8 cycles.
REQ-034 SHALL: CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, "123456789" -> 0x29B1.
REQ-035 SHALL: defaults, single word 0x01 with sof+last -> 0x07; then word 0x01 with sof, rst pulse mid-SHIFT (BPC=1), then word 0x01 with sof+last -> exactly one crc_valid, value 0x07.
REQ-036 SHALL: CRC_CHECK_EN, "123456789" with exp_crc=0xF4 -> crc_ok=1, crc_err=0; repeat with exp_crc=0xF5 -> crc_ok=0, crc_err pulses once.
REQ-037 SHALL: in_valid held high continuously with default BPC -> accepts spaced exactly 2 clocks apart, no word lost or duplicated.
